ser_feeder: RTL and testbench

SER_FEEDER -- requirements
Module: ser_feeder

---
 rtl/ser_feeder_pkg.sv | 17 +
 rtl/ser_bit_counter.sv | 34 +++
 rtl/ser_feeder.sv | 131 +++++++++++++
 tb/tb_ser_feeder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ser_feeder_pkg.sv
// rtl/ser_feeder_pkg.sv - shared state encoding and defaults for ser_feeder
// Optional feature macro: SER_FEEDER_PARITY_EN (adds the PARITY state).
package ser_feeder_pkg;

    // Level ser_out rests at between frames unless the instance overrides it.
    localparam logic SER_FEEDER_IDLE_BIT = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
`ifdef SER_FEEDER_PARITY_EN
        ,
        ST_PARITY = 2'd2
`endif
    } ser_feeder_state_t;

endpackage

// File: rtl/ser_bit_counter.sv
// rtl/ser_bit_counter.sv - loadable down-counter with terminal-count flag
// Ports:
//   clock    - rising-edge clock
//   rst      - synchronous active-high reset, clears the count
//   load     - load load_val (has priority over en)
//   load_val - value to load
//   en       - decrement by one; holds at zero instead of wrapping
//   tc       - count is zero
module ser_bit_counter #(
    parameter int unsigned CW = 4
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          tc
);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/ser_feeder.sv
// rtl/ser_feeder.sv - parallel-to-serial frame feeder, MSB first, zero-gap back-to-back frames
// Optional feature macro: SER_FEEDER_PARITY_EN (appends an even-parity bit after the LSB).
// Ports:
//   clock      - rising-edge clock
//   rst        - synchronous active-high reset
//   data_in    - parallel word to serialize
//   data_valid - data_in holds a valid word
//   data_ready - a word is accepted this cycle if data_valid is high
//   ser_out    - registered serial bit stream, one bit per clock
//   ser_active - ser_out carries a frame bit this cycle
//   frame_done - ser_out carries the last bit of the current frame
module ser_feeder
    import ser_feeder_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter logic        IDLE_BIT = SER_FEEDER_IDLE_BIT
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_active,
    output logic             frame_done
);

    localparam int unsigned   CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(WIDTH - 1);

    ser_feeder_state_t state;
    ser_feeder_state_t state_nxt;

    logic             accept;
    logic             last_bit;
    logic             bit_tc;
    logic [WIDTH-1:0] shreg;
    logic             ser_out_q;
`ifdef SER_FEEDER_PARITY_EN
    logic             parity_q;
`endif

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        last_bit   = 1'b0;
        ser_active = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_IDLE;
            end
            ST_SHIFT: begin
                ser_active = 1'b1;
                if (bit_tc) begin
`ifdef SER_FEEDER_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    last_bit  = 1'b1;
                    state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef SER_FEEDER_PARITY_EN
            ST_PARITY: begin
                ser_active = 1'b1;
                last_bit   = 1'b1;
                state_nxt  = ST_IDLE;
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // The ready window covers the final bit so the next word follows with no gap.
        data_ready = !rst && ((state == ST_IDLE) || last_bit);
        accept     = data_valid && data_ready;
        if (accept) begin
            state_nxt = ST_SHIFT;
        end
        frame_done = last_bit;
    end

    // Counter sits at WIDTH-1 on the first bit and reaches zero on the LSB.
    ser_bit_counter #(
        .CW (CW)
    ) u_bit_counter (
        .clock    (clock),
        .rst      (rst),
        .load     (accept),
        .load_val (LOAD_VAL),
        .en       (state == ST_SHIFT),
        .tc       (bit_tc)
    );

    // The MSB goes straight to ser_out on acceptance; shreg holds the rest left-aligned.
    always_ff @(posedge clock) begin
        if (rst) begin
            ser_out_q <= IDLE_BIT;
            shreg     <= '0;
`ifdef SER_FEEDER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else if (accept) begin
            ser_out_q <= data_in[WIDTH-1];
            shreg     <= data_in << 1;
`ifdef SER_FEEDER_PARITY_EN
            parity_q  <= ^data_in;
`endif
        end else if ((state == ST_SHIFT) && !bit_tc) begin
            ser_out_q <= shreg[WIDTH-1];
            shreg     <= shreg << 1;
`ifdef SER_FEEDER_PARITY_EN
        end else if (state == ST_SHIFT) begin
            ser_out_q <= parity_q;
`endif
        end else begin
            ser_out_q <= IDLE_BIT;
        end
    end

    assign ser_out = ser_out_q;

endmodule

// File: tb/tb_ser_feeder.sv
// tb/tb_ser_feeder.sv - directed self-checking bench for ser_feeder
module tb_ser_feeder;

`ifdef SER_FEEDER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = 8 + PAR;

    logic       clock;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       ser_out;
    logic       ser_active;
    logic       frame_done;

    int n_assert = 0;
    int n_fail   = 0;

    ser_feeder #(
        .WIDTH    (8),
        .IDLE_BIT (1'b0)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .ser_out    (ser_out),
        .ser_active (ser_active),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] w, input int k);
        if (k < 8) return w[7-k];
        return ^w;
    endfunction

    // Called at a negedge while idle; leaves the bench at the first cycle after the frame.
    // Valid is held high with junk data mid-frame to show the latched word is untouched.
    task automatic run_frame(input logic [7:0] w, input string tag);
        data_in    = w;
        data_valid = 1'b1;
        check({tag, "_ready_idle"}, data_ready, 1);
        @(negedge clock);
        for (int k = 0; k < FL; k++) begin
            check($sformatf("%s_bit%0d", tag, k), ser_out, exp_bit(w, k));
            check($sformatf("%s_active%0d", tag, k), ser_active, 1);
            check($sformatf("%s_done%0d", tag, k), frame_done, (k == FL - 1));
            check($sformatf("%s_ready%0d", tag, k), data_ready, (k == FL - 1));
            data_in    = 8'h3C;
            data_valid = (k != FL - 1);
            @(negedge clock);
        end
        check({tag, "_after_out"}, ser_out, 0);
        check({tag, "_after_active"}, ser_active, 0);
        check({tag, "_after_done"}, frame_done, 0);
    endtask

    initial begin
        logic [7:0] words [2];

        rst        = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'hA5;

        // Reset held two cycles with a valid word presented.
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            check("rst_ready", data_ready, 0);
            check("rst_out", ser_out, 0);
            check("rst_active", ser_active, 0);
            check("rst_done", frame_done, 0);
        end
        rst        = 1'b0;
        data_valid = 1'b0;

        // Idle for 10 cycles: no frame without a handshake.
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check("idle_ready", data_ready, 1);
            check("idle_out", ser_out, 0);
            check("idle_active", ser_active, 0);
        end

        // Single frames.
        run_frame(8'hB4, "b4");
        run_frame(8'h81, "x81");

        // Back-to-back frames with valid held.
        words[0]   = 8'hF0;
        words[1]   = 8'h0F;
        data_in    = words[0];
        data_valid = 1'b1;
        @(negedge clock);
        data_in = words[1];
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FL; k++) begin
                check($sformatf("b2b_bit%0d_%0d", f, k), ser_out, exp_bit(words[f], k));
                check($sformatf("b2b_active%0d_%0d", f, k), ser_active, 1);
                check($sformatf("b2b_done%0d_%0d", f, k), frame_done, (k == FL - 1));
                if (f == 1) data_valid = 1'b0;
                @(negedge clock);
            end
        end
        check("b2b_after_active", ser_active, 0);
        check("b2b_after_out", ser_out, 0);

        // Reset during bit 4 of 0xFF, then a clean 0x81 frame.
        data_in    = 8'hFF;
        data_valid = 1'b1;
        @(negedge clock);
        data_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ff_bit%0d", k), ser_out, 1);
            check($sformatf("ff_active%0d", k), ser_active, 1);
            if (k == 3) rst = 1'b1;
            @(negedge clock);
        end
        check("abort_out", ser_out, 0);
        check("abort_active", ser_active, 0);
        check("abort_done", frame_done, 0);
        check("abort_ready", data_ready, 0);
        rst = 1'b0;
        @(negedge clock);
        check("post_rst_out", ser_out, 0);
        check("post_rst_active", ser_active, 0);
        check("post_rst_ready", data_ready, 1);
        run_frame(8'h81, "post81");

`ifdef SER_FEEDER_PARITY_EN
        run_frame(8'hB4, "par_b4");
        run_frame(8'hB5, "par_b5");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
